// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// ysyx_22041071_axi_rd_arb_pkg: bus widths, AXI codes, grant ids and FSM state encodings for the read arbiter
package ysyx_22041071_axi_rd_arb_pkg;
  localparam int ADDR_BUS = 64;
  localparam int DATA_BUS = 64;
  localparam int AXI_LEN_WIDTH = 8;
  localparam int SIZE_D = 2;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_MEM = 1'b1;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_e;
endpackage

// File: rtl/ysyx_22041071_axi_rd_arb_pick.sv
// ysyx_22041071_arb_pick: combinational winner select; ports if_valid_i/mem_valid_i/last_grant_i in, grant_o/grant_valid_o out; YSYX_22041071_ARB_RR_EN selects round-robin over fixed mem priority
module ysyx_22041071_arb_pick
  import ysyx_22041071_axi_rd_arb_pkg::*;
(
  input  logic if_valid_i,
  input  logic mem_valid_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic grant_valid_o
);
  assign grant_valid_o = if_valid_i | mem_valid_i;
`ifdef YSYX_22041071_ARB_RR_EN
  assign grant_o = (if_valid_i & mem_valid_i) ? ~last_grant_i : (mem_valid_i ? GNT_MEM : GNT_IF);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_o = mem_valid_i ? GNT_MEM : GNT_IF;
`endif
endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// ysyx_22041071_axi_rd_arb: arbitrates if/mem read requests onto one AXI read master, one transaction outstanding; ports: clk/reset, per-requester ar (valid/addr/len/size/ready) and r (valid/data/resp/last), AXI ar*/r* master; macro YSYX_22041071_ARB_RR_EN enables round-robin
module ysyx_22041071_axi_rd_arb
  import ysyx_22041071_axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int DATA_W = DATA_BUS,
  parameter int LEN_W = AXI_LEN_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_ar_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [1:0]        if_size,
  output logic              if_ar_ready,
  output logic              if_r_valid,
  output logic [DATA_W-1:0] if_r_data,
  output logic [1:0]        if_r_resp,
  output logic              if_r_last,
  input  logic              mem_ar_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LEN_W-1:0]  mem_len,
  input  logic [1:0]        mem_size,
  output logic              mem_ar_ready,
  output logic              mem_r_valid,
  output logic [DATA_W-1:0] mem_r_data,
  output logic [1:0]        mem_r_resp,
  output logic              mem_r_last,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [SIZE_D-1:0] size_q, size_d;
  logic gnt_q, gnt_d, gnt, gnt_v, last_gnt, accept, beat;
  logic unused_rid;
  assign unused_rid = ^rid;
  ysyx_22041071_arb_pick u_pick (
    .if_valid_i   (if_ar_valid),
    .mem_valid_i  (mem_ar_valid),
    .last_grant_i (last_gnt),
    .grant_o      (gnt),
    .grant_valid_o(gnt_v)
  );
  // Outputs are gated with reset so an abandoned transaction never leaks a handshake in the reset cycle itself.
  assign accept = ~reset & (state_q == S_IDLE) & gnt_v;
  always_comb begin
    state_d = accept ? S_ADDR
            : (state_q == S_ADDR && arready) ? S_DATA
            : (state_q == S_DATA && rvalid && rlast) ? S_IDLE
            : state_q;
    addr_d = accept ? (gnt ? mem_addr : if_addr) : addr_q;
    len_d = accept ? (gnt ? mem_len : if_len) : len_q;
    size_d = accept ? (gnt ? mem_size : if_size) : size_q;
    gnt_d = accept ? gnt : gnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      gnt_q <= GNT_IF;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      gnt_q <= gnt_d;
    end
  end
`ifdef YSYX_22041071_ARB_RR_EN
  logic last_q;
  always_ff @(posedge clk) begin
    if (reset) last_q <= GNT_IF;
    else if (accept) last_q <= gnt;
  end
  assign last_gnt = last_q;
`else
  assign last_gnt = GNT_IF;
`endif
  assign if_ar_ready = accept & (gnt == GNT_IF);
  assign mem_ar_ready = accept & (gnt == GNT_MEM);
  assign arvalid = ~reset & (state_q == S_ADDR);
  assign araddr = addr_q;
  assign arlen = len_q;
  assign arsize = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign arid = {3'b000, gnt_q};
  assign rready = ~reset & (state_q == S_DATA);
  assign beat = rready & rvalid;
  assign if_r_valid = beat & (gnt_q == GNT_IF);
  assign mem_r_valid = beat & (gnt_q == GNT_MEM);
  assign if_r_data = rdata;
  assign mem_r_data = rdata;
  assign if_r_resp = rresp;
  assign mem_r_resp = rresp;
  assign if_r_last = if_r_valid & rlast;
  assign mem_r_last = mem_r_valid & rlast;
endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
YSYX_22041071_AXI_RD_ARB -- requirements
Module: ysyx_22041071_axi_rd_arb

Interface
REQ-001 Parameters SHALL be: ADDR_W, 64, address width; DATA_W, 64, read data width; LEN_W, 8, AXI burst-length width.
REQ-002 Clock/reset ports SHALL be: clk  in  1  sole clock, all logic on posedge; reset  in  1  synchronous, active-high reset.
REQ-003 Per requester i in {if, mem}, the ports SHALL be: <i>_ar_valid  in  1  read request; <i>_addr  in  ADDR_W  start address; <i>_len  in  LEN_W  beats-1; <i>_size  in  2  beat size; <i>_ar_ready  out  1  request accepted.
REQ-004 Per requester, the response ports SHALL be: <i>_r_valid  out  1  beat valid; <i>_r_data  out  DATA_W  beat data; <i>_r_resp  out  2  beat response; <i>_r_last  out  1  final beat.
REQ-005 The AXI master ports SHALL be: arvalid  out  1; arready  in  1; araddr  out  ADDR_W; arlen  out  LEN_W; arsize  out  3; arburst  out  2; arid  out  4; rvalid  in  1; rready  out  1; rdata  in  DATA_W; rresp  in  2; rlast  in  1; rid  in  4.

Function
REQ-006 The FSM SHALL have states IDLE, ADDR and DATA, with exactly one read transaction outstanding at a time.
REQ-007 In IDLE, when any <i>_ar_valid is 1, the block SHALL pick a winner combinationally, assert <winner>_ar_ready for that cycle, register the winner's addr/len/size and grant index, and move to ADDR.
REQ-008 <i>_ar_ready SHALL be 0 in ADDR and DATA, and always 0 for the losing requester.
REQ-009 In ADDR, arvalid SHALL be 1 with araddr/arlen/arsize held stable until arvalid&arready; on that edge the FSM SHALL move to DATA.
REQ-010 arsize SHALL be {1'b0, latched size}; arburst SHALL be INCR (2'b01); arid SHALL be the grant index (0 = if, 1 = mem).
REQ-011 In DATA, rready SHALL be 1 and rvalid/rdata/rresp/rlast SHALL pass combinationally to the granted requester; the other requester's r_valid SHALL be 0.
REQ-012 On rvalid&rready&rlast, the FSM SHALL return to IDLE, and a new grant SHALL be possible in the next cycle at the earliest.
REQ-013 A non-OKAY rresp SHALL be forwarded unchanged and SHALL NOT end the burst early; only rlast ends it.
REQ-014 rid SHALL be ignored for routing.
REQ-015 Minimum latency SHALL be: request accepted in cycle N, arvalid asserted in N+1, first beat forwarded in the same cycle rvalid arrives.
REQ-016 With the round-robin feature compiled out, simultaneous requests SHALL be granted to mem (fixed priority).

Reset
REQ-017 Reset SHALL force IDLE and drive arvalid=0, rready=0, both *_ar_ready=0, both *_r_valid=0, and latched araddr/arlen/arsize/arid=0.
REQ-018 Reset SHALL set the last-grant register to 0 (if).
REQ-019 Reset asserted in ADDR or DATA SHALL abandon the transaction; no beat SHALL be forwarded during or after reset for that transaction.

Configuration
REQ-020 The macro YSYX_22041071_ARB_RR_EN SHALL select the round-robin feature.
REQ-021 With YSYX_22041071_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the last-grant register SHALL update on each accepted request.
REQ-022 With YSYX_22041071_ARB_RR_EN undefined, REQ-016 SHALL apply and the last-grant register SHALL NOT be synthesized.
REQ-023 A single requester SHALL be granted immediately in either configuration.

Structure
REQ-024 The shared define header SHALL hold ADDR_BUS, AXI_LEN_WIDTH, SIZE_D, the INCR burst code, RESP_OKAY, the grant ids and the FSM state encodings.
REQ-025 Winner selection SHALL be one combinational sub-module, ysyx_22041071_arb_pick (inputs: two valids and last_grant; output: grant index and grant-valid).

Verification
REQ-026 The bench SHALL check: if-only request addr=0x8000_0000, len=0, size=3, arready=1 -> if_ar_ready in one cycle; arvalid next cycle with araddr=0x8000_0000, arsize=3, arid=0; one beat 0xDEAD_BEEF forwarded to if; back to IDLE.
REQ-027 The bench SHALL check: both request in the same cycle, fixed priority -> mem granted (arid=1) and if_ar_ready=0; if granted once mem's rlast has been seen.
REQ-028 The bench SHALL check: the same stimulus with YSYX_22041071_ARB_RR_EN defined, repeated 4 times -> grants alternate mem, if, mem, if.
REQ-029 The bench SHALL check: arready held 0 for 5 cycles -> arvalid and araddr stable for all 5 cycles, then transfer on the 6th.
REQ-030 The bench SHALL check: burst len=3 with rresp=SLVERR on beat 2 -> all 4 beats forwarded with resp intact; r_last only on beat 4.
REQ-031 The bench SHALL check: reset pulsed in DATA after beat 1 of 4 -> IDLE, rready=0 and no r_valid to either requester during or after reset.
